uc_engine_port: RTL

Engine-side endpoint of the unit-clause arbiter protocol; one instance per engine, `NUM_ENGINE instances total. Sources the engine's locally implied unit literals to the arbiter on `eng2uca_min` / `eng2uca_valid` / `eng2uca_empty`. Captures arbiter broadcasts (`uca2eng` qualified by `uca2eng_pop`) into an inbound queue for the engine core, and back-pressures the arbiter via `eng2uca_full`. Halts and flushes on arbiter `conflict` until the core restarts it.

---
 rtl/uc_engine_port.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uc_engine_port.sv
// uc_engine_port: engine-side endpoint of the unit-clause arbiter protocol.
// Sources locally implied literals to the arbiter through an outbound queue,
// captures arbiter broadcasts into an inbound first-word-fall-through queue,
// and halts/flushes on conflict until the core restarts it.
// Optional feature macro: UCP_SELF_FILTER_EN (drop own echoed literals inbound).

`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 255
`endif

module uc_engine_port #(
  parameter int LIT_W     = $clog2(`LIT_IDX_MAX) + 1,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [LIT_W-1:0] uca2eng,
  input  logic                    uca2eng_pop,
  input  logic                    conflict,
  output logic signed [LIT_W-1:0] eng2uca_min,
  output logic                    eng2uca_valid,
  output logic                    eng2uca_empty,
  output logic                    eng2uca_full,
  input  logic                    core_imp_valid,
  input  logic signed [LIT_W-1:0] core_imp_lit,
  output logic                    core_imp_ready,
  output logic                    core_uc_valid,
  output logic signed [LIT_W-1:0] core_uc_lit,
  input  logic                    core_uc_rd,
  input  logic                    core_restart,
  output logic                    halted,
  output logic                    overflow
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = IN_AW + 1;
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = OUT_AW + 1;

  localparam logic [IN_CW-1:0]  IN_FULL_CNT  = IN_CW'(IN_DEPTH);
  localparam logic [IN_CW-1:0]  IN_ALMOST    = IN_CW'(IN_DEPTH - 1);
  localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t state_q, state_d;

  logic signed [LIT_W-1:0] out_mem_q [OUT_DEPTH];
  logic signed [LIT_W-1:0] in_mem_q  [IN_DEPTH];

  logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [OUT_CW-1:0] out_count_q, out_count_d;
  logic [IN_AW-1:0]  in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [IN_CW-1:0]  in_count_q, in_count_d;
  logic              overflow_q, overflow_d;

  logic                    run;
  logic                    out_nonempty, in_nonempty, in_is_full;
  logic                    out_has_room;
  logic signed [LIT_W-1:0] out_head, in_head;
  logic                    out_push, out_pop, in_wr_req, in_rd;
  logic                    out_we, in_we;

  assign run          = (state_q == ST_RUN);
  assign out_nonempty = (out_count_q != '0);
  assign in_nonempty  = (in_count_q != '0);
  assign in_is_full   = (in_count_q == IN_FULL_CNT);
  assign out_has_room = (out_count_q < OUT_FULL_CNT);
  assign out_head     = out_mem_q[out_rd_ptr_q];
  assign in_head      = in_mem_q[in_rd_ptr_q];

  // Raw request decode; the FSM below gates these with RUN and conflict.
  // Room is judged from the registered count, so a same-cycle pop never frees a slot.
  assign out_push = core_imp_valid && out_has_room && (core_imp_lit != '0);
  assign out_pop  = uca2eng_pop && out_nonempty && (uca2eng == out_head);
  assign in_rd    = core_uc_rd && in_nonempty;

`ifdef UCP_SELF_FILTER_EN
  // An echo of our own head literal is already known locally; keep it out of the inbound queue.
  assign in_wr_req = uca2eng_pop && !out_pop;
`else
  assign in_wr_req = uca2eng_pop;
`endif

  // Next-state decode: FSM transitions, queue pointer/count updates, overflow tracking.
  always_comb begin
    state_d      = state_q;
    out_wr_ptr_d = out_wr_ptr_q;
    out_rd_ptr_d = out_rd_ptr_q;
    out_count_d  = out_count_q;
    in_wr_ptr_d  = in_wr_ptr_q;
    in_rd_ptr_d  = in_rd_ptr_q;
    in_count_d   = in_count_q;
    overflow_d   = overflow_q;
    out_we       = 1'b0;
    in_we        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (conflict) begin
          // Conflict wins over any same-cycle traffic and flushes both queues.
          state_d      = ST_HALT;
          out_wr_ptr_d = '0;
          out_rd_ptr_d = '0;
          out_count_d  = '0;
          in_wr_ptr_d  = '0;
          in_rd_ptr_d  = '0;
          in_count_d   = '0;
        end else begin
          out_we = out_push;
          if (out_push) out_wr_ptr_d = out_wr_ptr_q + OUT_AW'(1);
          if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(1);
          if (out_push && !out_pop)      out_count_d = out_count_q + OUT_CW'(1);
          else if (!out_push && out_pop) out_count_d = out_count_q - OUT_CW'(1);

          // A full queue still takes a write when the head is consumed in the same cycle.
          in_we = in_wr_req && (!in_is_full || in_rd);
          if (in_wr_req && in_is_full && !in_rd) overflow_d = 1'b1;
          if (in_we) in_wr_ptr_d = in_wr_ptr_q + IN_AW'(1);
          if (in_rd) in_rd_ptr_d = in_rd_ptr_q + IN_AW'(1);
          if (in_we && !in_rd)      in_count_d = in_count_q + IN_CW'(1);
          else if (!in_we && in_rd) in_count_d = in_count_q - IN_CW'(1);
        end
      end
      ST_HALT: begin
        if (core_restart && !conflict) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, pointer, count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_count_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_count_q   <= in_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Queue storage: one write-enabled register per entry; contents are only
  // observed through the counts, so no reset is needed.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_DEPTH; gi++) begin : g_out_mem
      // Capture an accepted implied literal into its slot.
      always_ff @(posedge clk) begin
        if (out_we && (out_wr_ptr_q == OUT_AW'(gi))) out_mem_q[gi] <= core_imp_lit;
      end
    end
    for (gi = 0; gi < IN_DEPTH; gi++) begin : g_in_mem
      // Capture an accepted broadcast literal into its slot.
      always_ff @(posedge clk) begin
        if (in_we && (in_wr_ptr_q == IN_AW'(gi))) in_mem_q[gi] <= uca2eng;
      end
    end
  endgenerate

  // Outputs decode registered state only; HALT forces the handshake outputs idle.
  assign eng2uca_valid  = run && out_nonempty;
  assign eng2uca_empty  = !eng2uca_valid;
  assign eng2uca_min    = eng2uca_valid ? out_head : '0;
  assign eng2uca_full   = run && (in_count_q >= IN_ALMOST);
  assign core_imp_ready = run && out_has_room;
  assign core_uc_valid  = run && in_nonempty;
  assign core_uc_lit    = core_uc_valid ? in_head : '0;
  assign halted         = !run;
  assign overflow       = overflow_q;

endmodule
